// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator for raster-order 8-bit pixels.
// Two line buffers hold the previous two image rows. A two-column shift window
// plus the column arriving now form the 3x3 neighbourhood. Only fully-interior
// (valid) windows are emitted, one cycle after the pixel that completes them.
module conv_window_gen #(
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_data,
  output logic [7:0] w1,
  output logic [7:0] w2,
  output logic [7:0] w3,
  output logic [7:0] w4,
  output logic [7:0] w5,
  output logic [7:0] w6,
  output logic [7:0] w7,
  output logic [7:0] w8,
  output logic [7:0] w9,
  output logic       multi_act,
  output logic [7:0] win_row,
  output logic [7:0] win_col,
  output logic       frame_done
);

  localparam int unsigned AW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [7:0]  LastCol = 8'(IMG_W - 1);
  localparam logic [7:0]  LastRow = 8'(IMG_H - 1);

  // Position of the next pixel to be accepted
  logic [7:0] row_q, col_q;
  // Position of the pixel on the input this cycle (start-of-frame overrides)
  logic [7:0] row_eff, col_eff;
  logic [AW-1:0] lb_idx;

  // Line buffers: lb_mid holds row r-1, lb_top holds row r-2 (relative to row_eff)
  logic [7:0] lb_mid_q [IMG_W];
  logic [7:0] lb_top_q [IMG_W];

  // Two previous columns of the window; index 0 is the leftmost
  logic [7:0] sh_top_q [2];
  logic [7:0] sh_mid_q [2];
  logic [7:0] sh_bot_q [2];

  // Column entering the window this cycle
  logic [7:0] new_top, new_mid, new_bot;

  logic accept;
  logic win_valid;
  logic win_last;

  logic [7:0] win_q [9];
  logic [7:0] win_row_q, win_col_q;
  logic       multi_act_q, frame_done_q;

  // Decode effective position, tap line buffers and qualify window emission
  always_comb begin
    accept    = in_valid & ~rst;
    row_eff   = in_sof ? 8'd0 : row_q;
    col_eff   = in_sof ? 8'd0 : col_q;
    lb_idx    = col_eff[AW-1:0];
    new_top   = lb_top_q[lb_idx];
    new_mid   = lb_mid_q[lb_idx];
    new_bot   = in_data;
    // Requiring col >= 2 keeps the shifted columns within the current row,
    // and row >= 2 guarantees both line buffers were filled by this frame.
    win_valid = accept && (row_eff >= 8'd2) && (col_eff >= 8'd2);
    win_last  = win_valid && (row_eff == LastRow) && (col_eff == LastCol);
  end

  // Pixel position counters, advanced only on accepted pixels
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= 8'd0;
      col_q <= 8'd0;
    end else if (accept) begin
      if (col_eff == LastCol) begin
        col_q <= 8'd0;
        row_q <= (row_eff == LastRow) ? 8'd0 : row_eff + 8'd1;
      end else begin
        col_q <= col_eff + 8'd1;
        row_q <= row_eff;
      end
    end
  end

  // Line-buffer and shift-window storage; contents never need clearing
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top_q[lb_idx] <= new_mid;
      lb_mid_q[lb_idx] <= new_bot;
      sh_top_q[0]      <= sh_top_q[1];
      sh_mid_q[0]      <= sh_mid_q[1];
      sh_bot_q[0]      <= sh_bot_q[1];
      sh_top_q[1]      <= new_top;
      sh_mid_q[1]      <= new_mid;
      sh_bot_q[1]      <= new_bot;
    end
  end

  // Registered window outputs; values hold until the next valid window
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 9; i++) begin
        win_q[i] <= 8'd0;
      end
      win_row_q    <= 8'd0;
      win_col_q    <= 8'd0;
      multi_act_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      multi_act_q  <= win_valid;
      frame_done_q <= win_last;
      if (win_valid) begin
        win_q[0]  <= sh_top_q[0];
        win_q[1]  <= sh_top_q[1];
        win_q[2]  <= new_top;
        win_q[3]  <= sh_mid_q[0];
        win_q[4]  <= sh_mid_q[1];
        win_q[5]  <= new_mid;
        win_q[6]  <= sh_bot_q[0];
        win_q[7]  <= sh_bot_q[1];
        win_q[8]  <= new_bot;
        win_row_q <= row_eff - 8'd2;
        win_col_q <= col_eff - 8'd2;
      end
    end
  end

  assign w1         = win_q[0];
  assign w2         = win_q[1];
  assign w3         = win_q[2];
  assign w4         = win_q[3];
  assign w5         = win_q[4];
  assign w6         = win_q[5];
  assign w7         = win_q[6];
  assign w8         = win_q[7];
  assign w9         = win_q[8];
  assign win_row    = win_row_q;
  assign win_col    = win_col_q;
  assign multi_act  = multi_act_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen at 4x4: directed table, corner-case sequences and
// randomized streams checked against an image-array reference model.
module tb_conv_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_data;
  logic [7:0] w1, w2, w3, w4, w5, w6, w7, w8, w9;
  logic       multi_act;
  logic [7:0] win_row, win_col;
  logic       frame_done;
  logic [7:0] dw [9];

  assign dw[0] = w1;
  assign dw[1] = w2;
  assign dw[2] = w3;
  assign dw[3] = w4;
  assign dw[4] = w5;
  assign dw[5] = w6;
  assign dw[6] = w7;
  assign dw[7] = w8;
  assign dw[8] = w9;

  always #5 clk = ~clk;

  conv_window_gen #(
    .IMG_W(W),
    .IMG_H(H)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .w1        (w1),
    .w2        (w2),
    .w3        (w3),
    .w4        (w4),
    .w5        (w5),
    .w6        (w6),
    .w7        (w7),
    .w8        (w8),
    .w9        (w9),
    .multi_act (multi_act),
    .win_row   (win_row),
    .win_col   (win_col),
    .frame_done(frame_done)
  );

  int tests = 0;
  int fails = 0;
  int act_seen = 0;

  // Reference model: the frame as a 2-D image plus the next pixel position
  int   img [H][W];
  int   mr, mc;
  int   m_w [9];
  logic m_act, m_fd;
  int   m_row, m_col;

  typedef struct {
    logic r, v, s;
    int   d;
    logic a, f;
    int   w1, w5, w9, row, col;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(logic r, logic v, logic s, int d, logic a, logic f,
                              int e1, int e5, int e9, int er, int ec);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.d = d; t.a = a; t.f = f;
    t.w1 = e1; t.w5 = e5; t.w9 = e9; t.row = er; t.col = ec;
    return t;
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model(input logic r, input logic v, input logic s, input int d);
    if (r) begin
      mr = 0; mc = 0; m_act = 0; m_fd = 0; m_row = 0; m_col = 0;
      for (int i = 0; i < 9; i++) m_w[i] = 0;
    end else begin
      m_act = 0;
      m_fd  = 0;
      if (v) begin
        if (s) begin
          mr = 0; mc = 0;
        end
        img[mr][mc] = d;
        if (mr >= 2 && mc >= 2) begin
          m_act = 1;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              m_w[i*3+j] = img[mr-2+i][mc-2+j];
          m_row = mr - 2;
          m_col = mc - 2;
          m_fd  = (mr == H-1) && (mc == W-1);
        end
        mc++;
        if (mc == W) begin
          mc = 0;
          mr = (mr + 1) % H;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic s, input int d);
    rst = r; in_valid = v; in_sof = s; in_data = 8'(d);
    @(posedge clk);
    model(r, v, s, d);
    #1;
    for (int i = 0; i < 9; i++) chk($sformatf("w%0d", i+1), dw[i], 8'(m_w[i]));
    chk("multi_act", {7'd0, multi_act}, {7'd0, m_act});
    chk("frame_done", {7'd0, frame_done}, {7'd0, m_fd});
    chk("win_row", win_row, 8'(m_row));
    chk("win_col", win_col, 8'(m_col));
    if (multi_act === 1'b1) act_seen++;
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int p = 1; p <= W*H; p++) begin
      if (gaps) step(0, 0, 0, 8'hEE);
      step(0, 1, p == 1, base + p);
    end
  endtask

  initial begin
    rst = 1; in_valid = 0; in_sof = 0; in_data = 0;

    // Directed table: reset then continuous 1..16 frame
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int p = 1; p <= 10; p++) tbl.push_back(mk(0, 1, p == 1, p, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 11, 1, 0, 1, 6, 11, 0, 0));
    tbl.push_back(mk(0, 1, 0, 12, 1, 0, 2, 7, 12, 0, 1));
    tbl.push_back(mk(0, 1, 0, 13, 0, 0, 2, 7, 12, 0, 1));
    tbl.push_back(mk(0, 1, 0, 14, 0, 0, 2, 7, 12, 0, 1));
    tbl.push_back(mk(0, 1, 0, 15, 1, 0, 5, 10, 15, 1, 0));
    tbl.push_back(mk(0, 1, 0, 16, 1, 1, 6, 11, 16, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6, 11, 16, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 6, 11, 16, 1, 1));

    foreach (tbl[k]) begin
      step(tbl[k].r, tbl[k].v, tbl[k].s, tbl[k].d);
      chk($sformatf("tbl%0d_act", k), {7'd0, multi_act}, {7'd0, tbl[k].a});
      chk($sformatf("tbl%0d_fd", k), {7'd0, frame_done}, {7'd0, tbl[k].f});
      chk($sformatf("tbl%0d_w1", k), w1, 8'(tbl[k].w1));
      chk($sformatf("tbl%0d_w5", k), w5, 8'(tbl[k].w5));
      chk($sformatf("tbl%0d_w9", k), w9, 8'(tbl[k].w9));
      chk($sformatf("tbl%0d_row", k), win_row, 8'(tbl[k].row));
      chk($sformatf("tbl%0d_col", k), win_col, 8'(tbl[k].col));
    end

    // Gapped stream: same four windows, outputs hold across gaps
    act_seen = 0;
    send_frame(0, 1);
    step(0, 0, 0, 0);
    chk("gap_window_count", 8'(act_seen), 8'd4);

    // Back-to-back frames: second frame's first window carries no old data
    act_seen = 0;
    send_frame(0, 0);
    for (int p = 1; p <= 11; p++) step(0, 1, p == 1, 100 + p);
    chk("b2b_count", 8'(act_seen), 8'd5);
    chk("b2b_w1", w1, 8'd101);
    chk("b2b_w9", w9, 8'd111);
    for (int p = 12; p <= 16; p++) step(0, 1, 0, 100 + p);

    // Reset mid-frame, then a full frame
    for (int p = 1; p <= 6; p++) step(0, 1, p == 1, p);
    step(1, 1, 0, 77);
    act_seen = 0;
    for (int p = 1; p <= 10; p++) step(0, 1, 0, p);
    chk("rst_no_early_window", 8'(act_seen), 8'd0);
    step(0, 1, 0, 11);
    chk("rst_first_w1", w1, 8'd1);
    chk("rst_first_w5", w5, 8'd6);
    for (int p = 12; p <= 16; p++) step(0, 1, 0, p);

    // Start-of-frame on pixel 9 mid-frame, then a fresh frame
    act_seen = 0;
    for (int p = 1; p <= 8; p++) step(0, 1, p == 1, p);
    step(0, 1, 1, 9);
    for (int p = 1; p <= 10; p++) step(0, 1, p == 1, p);
    chk("sof_no_early_window", 8'(act_seen), 8'd0);
    for (int p = 11; p <= 16; p++) step(0, 1, 0, p);
    chk("sof_window_count", 8'(act_seen), 8'd4);

    // Randomized streams with occasional sof and reset
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 39) == 0, int'($urandom_range(0, 255)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 The module SHALL have parameter IMG_W, default 32, meaning image width in pixels (legal range 3..256).
REQ-002 The module SHALL have parameter IMG_H, default 32, meaning image height in pixels (legal range 3..256).
REQ-003 The module SHALL have a single clock and a synchronous, active-high reset.
REQ-004 Port clk  input  1  rising-edge clock for all state.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port in_valid  input  1  pixel strobe; pixel accepted on any rising edge where in_valid=1 and rst=0.
REQ-007 Port in_sof  input  1  start of frame; qualified by in_valid; marks the accepted pixel as row 0, col 0.
REQ-008 Port in_data  input  8  raster-order pixel, unsigned.
REQ-009 Ports w1..w9  output  8 each  registered 3x3 window, row-major: w1/w2/w3 top row left to right, w7/w8/w9 bottom row left to right; ordering matches kernel taps k1..k9.
REQ-010 Port multi_act  output  1  one-cycle strobe: w1..w9 hold a new valid window.
REQ-011 Port win_row  output  8  top-left row of the current window.
REQ-012 Port win_col  output  8  top-left column of the current window.
REQ-013 Port frame_done  output  1  one-cycle strobe coincident with multi_act for the last window of a frame.

Function
REQ-014 The module SHALL hold pixel row and column counters, each updated only on accepted pixels; column wraps IMG_W-1 to 0 and increments row; row wraps IMG_H-1 to 0.
REQ-015 The module SHALL store two previous image lines in line buffers of IMG_W bytes each, plus a 3x3 shift window advanced once per accepted pixel.
REQ-016 Windows SHALL be valid-only (no padding): a window is produced for an accepted pixel at (r,c) with r>=2 and c>=2, giving window top-left (r-2,c-2).
REQ-017 Output count per frame SHALL be (IMG_H-2)*(IMG_W-2).
REQ-018 Latency SHALL be 1 cycle: multi_act, w1..w9, win_row and win_col update on the edge that accepts the completing pixel and are visible the following cycle.
REQ-019 multi_act SHALL be high for exactly one cycle per window; w1..w9, win_row and win_col SHALL hold their last values while multi_act=0.
REQ-020 Gaps in in_valid SHALL NOT alter state or outputs, except that multi_act and frame_done deassert.
REQ-021 Windows SHALL NOT straddle a row wrap: pixels from the previous row's tail never appear in the window after the column wraps.
REQ-022 frame_done SHALL assert with multi_act for the window at top-left (IMG_H-3, IMG_W-3); counters then return to (0,0).
REQ-023 An accepted pixel with in_sof=1 SHALL be treated as (0,0) regardless of counter state; any partial frame is discarded, and no window is produced until row 2, col 2 of the new frame.
REQ-024 Back-to-back frames SHALL need no reset; stale line-buffer contents SHALL never reach a multi_act window.
REQ-025 The module SHALL perform no arithmetic on pixel values; pixels SHALL pass through bit-exact.

Reset
REQ-026 On rst=1, counters, w1..w9, win_row, win_col, multi_act and frame_done SHALL all be 0 on the next edge.
REQ-027 in_valid SHALL be ignored while rst=1.
REQ-028 Line-buffer contents SHALL need no reset.
REQ-029 Reset mid-frame SHALL abandon the frame; the next accepted pixel is (0,0).

Verification (IMG_W=4, IMG_H=4, pixels 1..16 raster, in_sof on pixel 1)
REQ-030 Continuous stream: multi_act SHALL occur exactly 4 times, one cycle after pixels 11, 12, 15 and 16. Windows: (1,2,3,5,6,7,9,10,11) at (0,0); (2,3,4,6,7,8,10,11,12) at (0,1); (5,6,7,9,10,11,13,14,15) at (1,0); (6,7,8,10,11,12,14,15,16) at (1,1). frame_done SHALL be high only with the last window.
REQ-031 Same stream with in_valid low every other cycle: windows and values SHALL be identical, and outputs SHALL hold during gaps.
REQ-032 Second frame 101..116 sent immediately after the first: the first window SHALL be (101,102,103,105,106,107,109,110,111), with no first-frame data present.
REQ-033 rst pulsed after pixel 6, then a full frame 1..16 sent: outputs SHALL be 0 until the first window, which SHALL equal the REQ-030 result.
REQ-034 in_sof asserted on pixel 9 mid-frame, followed by a fresh 1..16: no window SHALL be emitted before the new frame's pixel 11.
